// File: rtl/itch_encoder.sv
// ITCH-style frame encoder: turns book_msg_t events into 64-bit Avalon-ST frames
// with a synthesized locate/tracking/timestamp header. One message in flight at a time.
package itch_pkg;
  typedef enum logic [2:0] {
    MSG_ADD     = 3'd0,
    MSG_CANCEL  = 3'd1,
    MSG_EXEC    = 3'd2,
    MSG_REPLACE = 3'd3,
    MSG_TRADE   = 3'd4
  } msg_type_e;

  typedef enum logic {
    SIDE_BID = 1'b0,
    SIDE_ASK = 1'b1
  } side_e;

  typedef struct packed {
    msg_type_e   mtype;
    side_e       side;
    logic [31:0] order_id;
    logic [31:0] price_tick;
    logic [31:0] qty;
  } book_msg_t;
endpackage

module itch_encoder
  import itch_pkg::*;
#(
  parameter int unsigned STREAM_W     = 64,
  parameter logic [15:0] STOCK_LOCATE = 16'h0001,
  parameter logic [63:0] STOCK_SYM    = 64'h5445_5354_2020_2020
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  book_msg_t           in_msg,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [STREAM_W-1:0] m_data,
  output logic                m_sop,
  output logic                m_eop,
  output logic [2:0]          m_empty,
  output logic                drop_pulse
);

  localparam int FrameBits = 320;

  typedef enum logic {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  book_msg_t   msg_q;
  logic [47:0] ts_cnt_q, ts_q;
  logic [15:0] trk_cnt_q, trk_q;
  logic [31:0] match_cnt_q, match_q;
  logic [2:0]  word_idx_q;
  logic        drop_q;

  logic           accept, type_ok, last_word;
  logic [2:0]     nwords, empty_cnt;
  logic [143:0]   hdr;
  logic [FrameBits-1:0] frame_be;

  assign accept    = in_valid && (state_q == StIdle);
  assign type_ok   = in_msg.mtype inside {MSG_ADD, MSG_CANCEL, MSG_EXEC};
  assign last_word = (word_idx_q == nwords - 3'd1);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    m_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid && type_ok) state_d = StSend;
      end
      StSend: begin
        m_valid = 1'b1;
        if (m_ready && last_word) state_d = StIdle;
      end
    endcase
  end

  // Whole frame as a big-endian byte string, left-justified; byte k sits at bits 319-8k.
  assign hdr = {STOCK_LOCATE, trk_q, ts_q, 32'h0, msg_q.order_id};

  always_comb begin
    nwords    = 3'd3;
    empty_cnt = 3'd4;
    frame_be  = '0;
    unique case (msg_q.mtype)
      MSG_ADD: begin
        nwords    = 3'd5;
        empty_cnt = 3'd3;
        frame_be  = {8'h24, 8'h41, hdr, (msg_q.side == SIDE_BID) ? 8'h42 : 8'h53,
                     msg_q.qty, STOCK_SYM, msg_q.price_tick, 24'h0};
      end
      MSG_EXEC: begin
        nwords    = 3'd4;
        empty_cnt = 3'd0;
        frame_be  = {8'h1F, 8'h45, hdr, msg_q.qty, 32'h0, match_q, 64'h0};
      end
      default: begin
        frame_be  = {8'h13, 8'h44, hdr, 160'h0};
      end
    endcase
  end

  always_comb begin
    m_data  = '0;
    m_sop   = 1'b0;
    m_eop   = 1'b0;
    m_empty = 3'd0;
    if (state_q == StSend) begin
      for (int l = 0; l < 8; l++) begin
        m_data[8*l +: 8] = frame_be[FrameBits - 1 - 64*int'(word_idx_q) - 8*l -: 8];
      end
      m_sop   = (word_idx_q == 3'd0);
      m_eop   = last_word;
      m_empty = last_word ? empty_cnt : 3'd0;
    end
  end

  assign drop_pulse = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      msg_q       <= '0;
      ts_cnt_q    <= '0;
      ts_q        <= '0;
      trk_cnt_q   <= '0;
      trk_q       <= '0;
      match_cnt_q <= '0;
      match_q     <= '0;
      word_idx_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_cnt_q <= ts_cnt_q + 48'd1;
      drop_q   <= accept && !type_ok;
      if (accept && type_ok) begin
        msg_q      <= in_msg;
        ts_q       <= ts_cnt_q;
        trk_q      <= trk_cnt_q;
        trk_cnt_q  <= trk_cnt_q + 16'd1;
        word_idx_q <= 3'd0;
        if (in_msg.mtype == MSG_EXEC) begin
          match_q     <= match_cnt_q;
          match_cnt_q <= match_cnt_q + 32'd1;
        end
      end else if (m_valid && m_ready) begin
        word_idx_q <= word_idx_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_itch_encoder.sv
// Self-checking bench for itch_encoder: directed steps plus randomized messages,
// each frame compared byte for byte against a byte-string model of the wire format.
module tb_itch_encoder;
  import itch_pkg::*;

  localparam logic [15:0] LOC = 16'h0001;
  localparam logic [63:0] SYM = 64'h5445_5354_2020_2020;

  logic        clk, rst_n, in_valid, in_ready, m_valid, m_ready, m_sop, m_eop, drop_pulse;
  book_msg_t   in_msg;
  logic [63:0] m_data;
  logic [2:0]  m_empty;

  int errors = 0;
  int checks = 0;

  logic [47:0] cyc;
  logic [15:0] trk_m;
  logic [31:0] match_m;
  logic [7:0]  exp_b [40];
  logic [7:0]  got_b [40];
  int          exp_len;

  itch_encoder #(
    .STREAM_W    (64),
    .STOCK_LOCATE(LOC),
    .STOCK_SYM   (SYM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .m_empty   (m_empty),
    .drop_pulse(drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running timestamp reference: number of clock edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 48'd1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic book_msg_t mk(input msg_type_e t, input side_e s, input logic [31:0] oid,
                                   input logic [31:0] price, input logic [31:0] qty);
    book_msg_t m;
    m.mtype      = t;
    m.side       = s;
    m.order_id   = oid;
    m.price_tick = price;
    m.qty        = qty;
    return m;
  endfunction

  task automatic put(input int off, input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) exp_b[off + i] = 8'(v >> (8 * (n - 1 - i)));
  endtask

  task automatic model_frame(input book_msg_t m, input logic [15:0] trk, input logic [47:0] ts,
                             input logic [31:0] mc);
    for (int k = 0; k < 40; k++) exp_b[k] = 8'h00;
    case (m.mtype)
      MSG_ADD: begin
        exp_len   = 37;
        exp_b[1]  = 8'h41;
        exp_b[20] = (m.side == SIDE_BID) ? 8'h42 : 8'h53;
        put(21, 4, 64'(m.qty));
        put(25, 8, SYM);
        put(33, 4, 64'(m.price_tick));
      end
      MSG_EXEC: begin
        exp_len  = 32;
        exp_b[1] = 8'h45;
        put(20, 4, 64'(m.qty));
        put(24, 8, 64'(mc));
      end
      default: begin
        exp_len  = 20;
        exp_b[1] = 8'h44;
      end
    endcase
    exp_b[0] = 8'(exp_len - 1);
    put(2, 2, 64'(LOC));
    put(4, 2, 64'(trk));
    put(6, 6, 64'(ts));
    put(12, 8, 64'(m.order_id));
  endtask

  function automatic logic [47:0] got_ts();
    logic [47:0] t = '0;
    for (int i = 0; i < 6; i++) t = {t[39:0], got_b[6 + i]};
    return t;
  endfunction

  // Offers one message, then drains its frame; stall=1 randomizes m_ready.
  task automatic send(input book_msg_t m, input bit stall);
    int          w, nw, emp, budget;
    bit          rdy, stalled;
    logic [47:0] t_ts;
    logic [63:0] ew, prev_data, prev_ctl;
    logic [127:0] junk;
    chk1("in_ready_before_offer", in_ready, 1'b1);
    in_valid = 1'b1;
    in_msg   = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    junk     = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_msg   = junk[$bits(book_msg_t)-1:0];
    t_ts     = cyc - 48'd1;
    if (!(m.mtype inside {MSG_ADD, MSG_CANCEL, MSG_EXEC})) begin
      chk1("drop_pulse_high", drop_pulse, 1'b1);
      chk1("drop_no_valid", m_valid, 1'b0);
      @(posedge clk); #1;
      chk1("drop_pulse_low", drop_pulse, 1'b0);
      chk1("drop_no_valid_after", m_valid, 1'b0);
      return;
    end
    model_frame(m, trk_m, t_ts, match_m);
    trk_m++;
    if (m.mtype == MSG_EXEC) match_m++;
    nw      = (exp_len + 7) / 8;
    emp     = nw * 8 - exp_len;
    w       = 0;
    budget  = 0;
    stalled = 1'b0;
    prev_data = '0;
    prev_ctl  = '0;
    while (w < nw && budget < 200) begin
      chk1("m_valid_in_frame", m_valid, 1'b1);
      chk1("in_ready_busy", in_ready, 1'b0);
      if (stalled) begin
        chk64("stall_data_stable", m_data, prev_data);
        chk64("stall_ctl_stable", 64'({m_sop, m_eop, m_empty}), prev_ctl);
      end
      for (int l = 0; l < 8; l++) ew[8*l +: 8] = exp_b[8*w + l];
      chk64("m_data", m_data, ew);
      chk1("m_sop", m_sop, w == 0);
      chk1("m_eop", m_eop, w == nw - 1);
      chk64("m_empty", 64'(m_empty), (w == nw - 1) ? 64'(emp) : 64'd0);
      for (int l = 0; l < 8; l++) got_b[8*w + l] = m_data[8*l +: 8];
      prev_data = m_data;
      prev_ctl  = 64'({m_sop, m_eop, m_empty});
      rdy       = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready   = rdy;
      @(posedge clk); #1;
      if (rdy) w++;
      stalled = !rdy;
      budget++;
    end
    chk1("frame_complete", w == nw, 1'b1);
    chk1("in_ready_after_eop", in_ready, 1'b1);
    chk1("m_valid_after_eop", m_valid, 1'b0);
  endtask

  initial begin
    book_msg_t   m;
    logic [47:0] ts1, ts2;
    logic [15:0] trk_save;
    msg_type_e   rt;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    in_msg   = '0;
    trk_m    = '0;
    match_m  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_m_valid", m_valid, 1'b0);
    chk64("rst_m_data", m_data, 64'h0);
    chk1("rst_m_sop", m_sop, 1'b0);
    chk1("rst_m_eop", m_eop, 1'b0);
    chk64("rst_m_empty", 64'(m_empty), 64'h0);
    chk1("rst_drop", drop_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("in_ready_after_rst", in_ready, 1'b1);

    // ADD with literal field checks.
    send(mk(MSG_ADD, SIDE_BID, 32'h1234_5678, 32'h0000_2710, 32'd100), 1'b0);
    chk64("add_len", 64'(got_b[0]), 64'h24);
    chk64("add_type", 64'(got_b[1]), 64'h41);
    chk64("add_locate", 64'({got_b[2], got_b[3]}), 64'h0001);
    chk64("add_trk", 64'({got_b[4], got_b[5]}), 64'h0000);
    chk64("add_oid", 64'({got_b[16], got_b[17], got_b[18], got_b[19]}), 64'h1234_5678);
    chk64("add_side", 64'(got_b[20]), 64'h42);
    chk64("add_qty", 64'({got_b[21], got_b[22], got_b[23], got_b[24]}), 64'h64);
    chk64("add_price", 64'({got_b[33], got_b[34], got_b[35], got_b[36]}), 64'h2710);

    send(mk(MSG_CANCEL, SIDE_ASK, 32'hDEAD_BEEF, 32'h0, 32'h0), 1'b0);
    chk64("cxl_len", 64'(got_b[0]), 64'h13);
    chk64("cxl_type", 64'(got_b[1]), 64'h44);
    chk64("cxl_trk", 64'({got_b[4], got_b[5]}), 64'h0001);
    chk64("cxl_oid", 64'({got_b[16], got_b[17], got_b[18], got_b[19]}), 64'hDEAD_BEEF);

    send(mk(MSG_EXEC, SIDE_BID, 32'h0000_0042, 32'h0, 32'd5), 1'b0);
    chk64("exec1_qty", 64'({got_b[20], got_b[21], got_b[22], got_b[23]}), 64'h5);
    chk64("exec1_match", 64'(got_b[31]), 64'h00);
    ts1 = got_ts();
    send(mk(MSG_EXEC, SIDE_BID, 32'h0000_0043, 32'h0, 32'd7), 1'b0);
    chk64("exec2_qty", 64'({got_b[20], got_b[21], got_b[22], got_b[23]}), 64'h7);
    chk64("exec2_match", 64'(got_b[31]), 64'h01);
    ts2 = got_ts();
    chk1("exec_ts_increasing", ts2 > ts1, 1'b1);

    // Backpressure.
    send(mk(MSG_ADD, SIDE_ASK, $urandom(), $urandom(), $urandom()), 1'b1);
    chk64("bp_side", 64'(got_b[20]), 64'h53);

    // Dropped type must not consume a tracking number.
    trk_save = trk_m;
    send(mk(MSG_TRADE, SIDE_BID, 32'h1, 32'h2, 32'h3), 1'b0);
    send(mk(MSG_ADD, SIDE_BID, $urandom(), $urandom(), $urandom()), 1'b0);
    chk64("post_drop_trk", 64'({got_b[4], got_b[5]}), 64'(trk_save));

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 6))
        0, 1:    rt = MSG_ADD;
        2, 3:    rt = MSG_CANCEL;
        4, 5:    rt = MSG_EXEC;
        default: rt = ($urandom_range(0, 1) == 0) ? MSG_REPLACE : MSG_TRADE;
      endcase
      m = mk(rt, side_e'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom());
      send(m, 1'($urandom_range(0, 1)));
    end

    // Reset during word 2 of an ADD.
    m_ready  = 1'b1;
    in_valid = 1'b1;
    in_msg   = mk(MSG_ADD, SIDE_BID, $urandom(), $urandom(), $urandom());
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("pre_rst_valid", m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("midrst_m_valid", m_valid, 1'b0);
    chk64("midrst_m_data", m_data, 64'h0);
    chk1("midrst_m_eop", m_eop, 1'b0);
    trk_m   = '0;
    match_m = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(mk(MSG_CANCEL, SIDE_BID, $urandom(), 32'h0, 32'h0), 1'b0);
    chk64("post_rst_trk", 64'({got_b[4], got_b[5]}), 64'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/itch_encoder.md
# itch_encoder

Serializes internal `book_msg_t` order-book events into ITCH-style binary frames on a 64-bit Avalon-ST source. It is the transmit-side counterpart of the ITCH parser. It drives feed-replay and loopback paths, so book events can be re-emitted as wire frames. Each frame carries a synthesized header: stock locate, tracking number, and a 48-bit timestamp. The block is one message deep: it accepts a message, streams it out word by word, then accepts the next.

## Interface
- `STREAM_W`, 64: stream data width. Only 64 is supported.
- `STOCK_LOCATE`, 16'h0001: constant stock-locate field.
- `STOCK_SYM`, 64'h5445_5354_2020_2020 ("TEST    "): stock field, emitted MSB byte first.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input message valid.
- `in_ready` out 1: block can accept a message.
- `in_msg` in `book_msg_t`: fields `mtype`, `side`, `order_id[31:0]`, `price_tick[31:0]`, `qty[31:0]`.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accepts the word.
- `m_data` out 64: frame bytes, little-endian lanes.
- `m_sop` out 1: first word of a frame.
- `m_eop` out 1: last word of a frame.
- `m_empty` out 3: unused byte lanes on the eop word.
- `drop_pulse` out 1: one-cycle pulse when an unsupported mtype is discarded.

## Operation
- **Byte mapping:** frame byte k is at `m_data[8*(k%8) +: 8]` of word k/8. Unused lanes of the eop word are driven 0.
- **Common header:**
  - byte 0 = Length, the number of bytes after byte 0.
  - byte 1 = type character.
  - bytes 2-3 = `STOCK_LOCATE`.
  - bytes 4-5 = tracking number.
  - bytes 6-11 = timestamp.
  - bytes 12-19 = order reference, i.e. {32'h0, `order_id`}.
  - All multi-byte fields are big-endian.
- **MSG_ADD → 'A' (0x41):** 37 bytes, Length 0x24, 5 words, eop `m_empty`=3.
  - byte 20: side, 'B' (0x42) for SIDE_BID, otherwise 'S' (0x53).
  - bytes 21-24: `qty`.
  - bytes 25-32: `STOCK_SYM`.
  - bytes 33-36: `price_tick`.
- **MSG_CANCEL → 'D' (0x44):** 20 bytes, Length 0x13, 3 words, `m_empty`=4.
- **MSG_EXEC → 'E' (0x45):** 32 bytes, Length 0x1F, 4 words, `m_empty`=0.
  - bytes 20-23: `qty`.
  - bytes 24-31: match number, {32'h0, match_cnt}.
- **Any other mtype:** the message is accepted and discarded. `drop_pulse`=1 in the cycle after the accept. Nothing is emitted and no counter changes.
- **Counters:** all clear to 0 on reset.
  - ts_cnt (48-bit) increments every clk and wraps.
  - trk_cnt (16-bit) increments once per accepted valid-type message and wraps 0xFFFF→0.
  - match_cnt (32-bit) increments once per accepted EXEC and wraps.
  - The value sampled at accept is the pre-increment value.
- **FSM:**
  - IDLE: `in_ready`=1. On `in_valid`:
    - latch `in_msg`, ts_cnt and trk_cnt (plus match_cnt for EXEC);
    - set word_idx=0 and nwords from the type;
    - go to SEND. An invalid type stays in IDLE.
  - SEND: `in_ready`=0, `m_valid`=1.
    - `m_data` shows word[word_idx].
    - `m_sop` = (word_idx==0).
    - `m_eop` = (word_idx==nwords-1).
    - `m_empty` shows the type's empty count on the eop word, 0 otherwise.
  - On `m_valid && m_ready`, word_idx increments. On the eop handshake, return to IDLE.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_sop`=0, `m_eop`=0, `m_empty`=0, `drop_pulse`=0. After reset release, `in_ready`=1.
- Latency: the first word is valid in the cycle after the `in_valid && in_ready` accept.
- Throughput: an N-word frame takes N cycles at full `m_ready`. After the eop handshake, IDLE costs 1 cycle, so one message per N+1 cycles.
- While `m_valid && !m_ready`, `m_data`, `m_sop`, `m_eop` and `m_empty` hold stable. `m_valid` never deasserts mid-frame.
- The outputs do not depend combinationally on `m_ready` or `in_valid`.
- Reset asserted mid-frame: `m_valid` drops immediately and the frame is abandoned with no eop. The next frame starts with sop and trk_cnt=0.
- `in_msg` is sampled only in the accept cycle. Later changes to it do not affect the frame in flight.

## Test plan
- **ADD:** after reset, ADD {BID, oid 0x12345678, price 0x00002710, qty 100} with `m_ready`=1.
  - 5 words.
  - byte0=0x24, byte1=0x41, bytes 2-3 = 00 01, bytes 4-5 = 00 00.
  - bytes 16-19 = 12 34 56 78, byte20=0x42, bytes 21-24 = 00 00 00 64, bytes 33-36 = 00 00 27 10.
  - sop on word0 only; eop on word4 with `m_empty`=3 and lanes 5-7 = 0.
- **CANCEL:** CANCEL oid 0xDEADBEEF.
  - 3 words, byte0=0x13, byte1=0x44, bytes 16-19 = DE AD BE EF.
  - word2 has `m_empty`=4 and upper 4 lanes = 0.
  - Tracking bytes 4-5 = 00 01 if it follows the ADD.
- **EXEC pair:** two EXECs, qty 5 then 7.
  - Each is 4 words with `m_empty`=0, byte0=0x1F, byte1=0x45.
  - bytes 20-23 = 00 00 00 05 and 00 00 00 07.
  - Match bytes 31 = 00 then 01.
  - Timestamps strictly increase.
- **Backpressure:** ADD with `m_ready` toggled pseudo-randomly.
  - Every stalled word stays stable.
  - `in_ready`=0 until the cycle after the eop handshake.
  - The byte contents match the no-stall case.
- **Drop:** an unsupported mtype encoding.
  - `drop_pulse` high for exactly 1 cycle; `m_valid` stays 0.
  - The next ADD carries the same tracking number the dropped message would have had.
- **Reset mid-frame:** assert `rst_n`=0 during word 2 of an ADD.
  - `m_valid`=0 immediately.
  - After release, a CANCEL emits sop on word0 with tracking 00 00.
